score_ram: RTL and testbench
============================

# score_ram

Score storage responder for the bomb-defusal game. It is the memory end of the score/level bus driven by the game's RAM controller. It accepts one read or write request per cycle on an 8-bit address/data bus with a single `r_w` strobe, and returns registered read data. After every reset it self-clears all entries to zero, and it optionally keeps only the highest value written per entry. It sits between the RAM controller and nothing else; the controller's `address_out`/`data_out`/`r_w` connect to this block's inputs, and this block's `data_out` feeds the controller's `data_in`.

## Interface
- `DEPTH`, 8: number of 8-bit entries; legal range 2..256.
- `KEEP_MAX`, 0: 0 = plain overwrite; 1 = a write updates an entry only if the new data is strictly greater than the stored data (unsigned).
- `clk`  in  1  on-board 50 MHz clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `r_w`  in  1  request type: 1 = write, 0 = read; sampled every cycle when not busy.
- `address_in`  in  8  entry address.
- `data_in`  in  8  write data.
- `data_out`  out  8  registered read data.
- `rd_valid`  out  1  one-cycle pulse: `data_out` was loaded by a read this cycle.
- `wr_done`  out  1  one-cycle pulse: the write request sampled last edge was accepted (stored, or rejected by `KEEP_MAX` compare).
- `addr_err`  out  1  one-cycle pulse: the request sampled last edge had `address_in >= DEPTH`.
- `busy`  out  1  high while clearing; requests are ignored.
- `wr_count`  out  8  count of writes that changed stored data; saturates at 255.

## Operation
- State machine:
  - CLEAR: entered on reset. `clr_ptr` walks 0..DEPTH-1 and writes 0 to `mem[clr_ptr]` each cycle.
  - CLEAR exits to SERVE after the cycle that clears entry DEPTH-1.
  - SERVE: stays there until the next reset.
- While `reset`=1: state=CLEAR, `clr_ptr`=0, `data_out`=0, `rd_valid`=0, `wr_done`=0, `addr_err`=0, `busy`=1, `wr_count`=0. Memory contents are undefined until CLEAR completes.
- CLEAR: `busy`=1. All requests are dropped, with no pulses and no errors.
- SERVE, `address_in >= DEPTH`:
  - No memory access; `addr_err`=1 next cycle.
  - `data_out` holds its value; `rd_valid` and `wr_done` stay 0.
- SERVE, `r_w`=0, address legal: `data_out <= mem[address_in]` and `rd_valid`=1 next cycle.
- SERVE, `r_w`=1, address legal:
  - `wr_done`=1 next cycle.
  - With `KEEP_MAX`=0, `mem <= data_in` always.
  - With `KEEP_MAX`=1, `mem <= data_in` only if `data_in > mem[address_in]`.
  - `wr_count` increments only when the stored value actually changes (new data differs from old). It saturates at 255 and never wraps.
- `r_w` held high for several cycles re-issues the write each cycle. This is idempotent for memory, and `wr_count` does not count repeats because the value is unchanged.
- `data_out` holds the last read value across writes, errors and idle cycles. A write never alters `data_out`.
- Address compare uses the full 8 bits with no aliasing. With DEPTH=256 no address is illegal.

## Timing
- `busy` is high during reset and for exactly DEPTH cycles after the first edge with `reset`=0.
- The first request is accepted on the edge after `busy` falls.
- Read latency: 1 cycle. The read sampled at edge N has its data on `data_out` with `rd_valid` after edge N.
- Write followed by a read of the same address on the next edge returns the new value.
- Back-to-back requests are accepted every cycle with no bubbles.
- Pulses (`rd_valid`, `wr_done`, `addr_err`) last exactly one cycle per request. At most one of them is high in any cycle.
- Reset asserted mid-CLEAR or mid-SERVE:
  - Takes effect at the next edge. Any in-flight request is discarded and all outputs go to their reset values.
  - CLEAR restarts from entry 0.

## Test plan
- Reset, DEPTH=8:
  - `busy`=1 for 8 cycles after reset release.
  - Reading addresses 0..7 afterwards returns 0x00 with `rd_valid` pulses; `wr_count`=0.
- KEEP_MAX=0:
  - Write 0x05 to addr 2, then read addr 2 on the next cycle → `data_out`=0x05 one cycle later, `wr_done` then `rd_valid`, `wr_count`=1.
  - Writing 0x05 again → `wr_count` stays 1.
- KEEP_MAX=1:
  - Write 0x07 then 0x03 to addr 1 → read returns 0x07, `wr_count`=1, two `wr_done` pulses.
  - Then write 0x09 → read returns 0x09, `wr_count`=2.
- Address error: read or write at addr 0x08 with DEPTH=8 → `addr_err` pulse, `data_out` unchanged, memory unchanged, no `wr_done`/`rd_valid`.
- Busy and reset:
  - A write of 0xAA to addr 0 issued during CLEAR is ignored; a later read returns 0x00.
  - Reset asserted after 300 distinct writes (with `wr_count`=255 saturated) → all outputs 0, `busy`=1.
  - After that reset, CLEAR restarts and every entry reads 0x00.

Source files
------------

// File: rtl/score_ram.sv
// Score/level storage responder: one read or write per cycle on an 8-bit bus,
// self-clears every entry after reset, optionally keeps only the per-entry maximum.
module score_ram #(
    parameter int DEPTH    = 8,
    parameter bit KEEP_MAX = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       r_w,
    input  logic [7:0] address_in,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       rd_valid,
    output logic       wr_done,
    output logic       addr_err,
    output logic       busy,
    output logic [7:0] wr_count
);

    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        CLEAR,
        SERVE
    } state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] clr_ptr_reg;
    logic [7:0]        data_out_reg;
    logic [7:0]        wr_count_reg;
    logic              rd_valid_reg;
    logic              wr_done_reg;
    logic              addr_err_reg;
    logic              busy_reg;

    logic [7:0]        mem [DEPTH];

    logic              addr_ok;
    logic [ADDR_W-1:0] addr_idx;
    logic [7:0]        old_data;
    logic              upd_ok;
    logic              changed;
    logic              serve_wr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wdata;

    // Full 9-bit compare so no address aliases onto a smaller memory.
    assign addr_ok  = ({1'b0, address_in} < 9'(DEPTH));
    assign addr_idx = address_in[ADDR_W-1:0];
    assign old_data = mem[addr_idx];
    assign changed  = (data_in != old_data);

    generate
        if (KEEP_MAX) begin : g_keep_max
            assign upd_ok = (data_in > old_data);
        end else begin : g_overwrite
            assign upd_ok = 1'b1;
        end
    endgenerate

    assign serve_wr = (state_reg == SERVE) && r_w && addr_ok && upd_ok;

    // Writes are suppressed while reset is asserted so an in-flight request is dropped.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr_idx;
        mem_wdata = data_in;
        if (!reset) begin
            if (state_reg == CLEAR) begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_reg;
                mem_wdata = 8'h00;
            end else if (serve_wr) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= CLEAR;
            clr_ptr_reg  <= '0;
            data_out_reg <= 8'h00;
            rd_valid_reg <= 1'b0;
            wr_done_reg  <= 1'b0;
            addr_err_reg <= 1'b0;
            busy_reg     <= 1'b1;
            wr_count_reg <= 8'h00;
        end else begin
            rd_valid_reg <= 1'b0;
            wr_done_reg  <= 1'b0;
            addr_err_reg <= 1'b0;
            case (state_reg)
                CLEAR: begin
                    if (clr_ptr_reg == ADDR_W'(DEPTH - 1)) begin
                        state_reg   <= SERVE;
                        busy_reg    <= 1'b0;
                        clr_ptr_reg <= '0;
                    end else begin
                        clr_ptr_reg <= clr_ptr_reg + 1'b1;
                    end
                end
                SERVE: begin
                    if (!addr_ok) begin
                        addr_err_reg <= 1'b1;
                    end else if (r_w) begin
                        wr_done_reg <= 1'b1;
                        // Only real value changes count, so repeated writes are free.
                        if (upd_ok && changed && (wr_count_reg != 8'hFF)) begin
                            wr_count_reg <= wr_count_reg + 8'd1;
                        end
                    end else begin
                        data_out_reg <= mem[addr_idx];
                        rd_valid_reg <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign data_out = data_out_reg;
    assign rd_valid = rd_valid_reg;
    assign wr_done  = wr_done_reg;
    assign addr_err = addr_err_reg;
    assign busy     = busy_reg;
    assign wr_count = wr_count_reg;

endmodule

// File: tb/tb_score_ram.sv
// Directed-vector bench for score_ram: one overwrite instance and one keep-max
// instance share the same stimulus; each vector carries expectations for both.
module tb_score_ram;

    logic       clk = 1'b0;
    logic       reset;
    logic       r_w;
    logic [7:0] address_in;
    logic [7:0] data_in;

    logic [7:0] data_out0, wr_count0, data_out1, wr_count1;
    logic       rd_valid0, wr_done0, addr_err0, busy0;
    logic       rd_valid1, wr_done1, addr_err1, busy1;

    int n_vec = 0;
    int n_err = 0;

    always #10 clk = ~clk;

    score_ram #(.DEPTH(8), .KEEP_MAX(1'b0)) dut0 (
        .clk(clk), .reset(reset), .r_w(r_w), .address_in(address_in), .data_in(data_in),
        .data_out(data_out0), .rd_valid(rd_valid0), .wr_done(wr_done0),
        .addr_err(addr_err0), .busy(busy0), .wr_count(wr_count0)
    );

    score_ram #(.DEPTH(8), .KEEP_MAX(1'b1)) dut1 (
        .clk(clk), .reset(reset), .r_w(r_w), .address_in(address_in), .data_in(data_in),
        .data_out(data_out1), .rd_valid(rd_valid1), .wr_done(wr_done1),
        .addr_err(addr_err1), .busy(busy1), .wr_count(wr_count1)
    );

    // pulses = {addr_err, wr_done, rd_valid}
    typedef struct {
        logic       r_w;
        logic [7:0] addr;
        logic [7:0] data;
        logic [2:0] pulses;
        logic [7:0] dout0;
        logic [7:0] cnt0;
        logic [7:0] dout1;
        logic [7:0] cnt1;
    } vec_t;

    localparam int NV = 23;
    vec_t vt [NV];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " dout0"}, data_out0, 8'h00);
        chk({tag, " dout1"}, data_out1, 8'h00);
        chk({tag, " pulses0"}, {5'd0, addr_err0, wr_done0, rd_valid0}, 8'h00);
        chk({tag, " pulses1"}, {5'd0, addr_err1, wr_done1, rd_valid1}, 8'h00);
        chk({tag, " busy"}, {6'd0, busy1, busy0}, 8'h03);
        chk({tag, " cnt0"}, wr_count0, 8'h00);
        chk({tag, " cnt1"}, wr_count1, 8'h00);
    endtask

    // Called at the negedge where reset has just been dropped; counts busy samples.
    task automatic wait_clear(input string tag);
        int n;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            if (!busy0) break;
            n++;
            chk({tag, " no pulses in clear"},
                {2'd0, addr_err1, wr_done1, rd_valid1, addr_err0, wr_done0, rd_valid0}, 8'h00);
            @(negedge clk);
        end
        chk({tag, " busy length"}, 8'(n), 8'd8);
        chk({tag, " busy1 low"}, {7'd0, busy1}, 8'h00);
    endtask

    task automatic read_all_zero(input string tag);
        for (int a = 0; a < 8; a++) begin
            r_w = 1'b0; address_in = 8'(a); data_in = 8'h00;
            @(negedge clk);
            chk($sformatf("%s rd%0d dout0", tag, a), data_out0, 8'h00);
            chk($sformatf("%s rd%0d dout1", tag, a), data_out1, 8'h00);
            chk($sformatf("%s rd%0d valid", tag, a), {6'd0, rd_valid1, rd_valid0}, 8'h03);
        end
    endtask

    logic [7:0] m0 [8];
    logic [7:0] m1 [8];
    logic [7:0] c0, c1;

    initial begin
        //        r_w   addr   data   pulses  dout0  cnt0   dout1  cnt1
        vt[0]  = '{1'b0, 8'd0, 8'h00, 3'b001, 8'h00, 8'd0, 8'h00, 8'd0};
        vt[1]  = '{1'b0, 8'd1, 8'h00, 3'b001, 8'h00, 8'd0, 8'h00, 8'd0};
        vt[2]  = '{1'b0, 8'd2, 8'h00, 3'b001, 8'h00, 8'd0, 8'h00, 8'd0};
        vt[3]  = '{1'b0, 8'd3, 8'h00, 3'b001, 8'h00, 8'd0, 8'h00, 8'd0};
        vt[4]  = '{1'b0, 8'd4, 8'h00, 3'b001, 8'h00, 8'd0, 8'h00, 8'd0};
        vt[5]  = '{1'b0, 8'd5, 8'h00, 3'b001, 8'h00, 8'd0, 8'h00, 8'd0};
        vt[6]  = '{1'b0, 8'd6, 8'h00, 3'b001, 8'h00, 8'd0, 8'h00, 8'd0};
        vt[7]  = '{1'b0, 8'd7, 8'h00, 3'b001, 8'h00, 8'd0, 8'h00, 8'd0};
        vt[8]  = '{1'b1, 8'd2, 8'h05, 3'b010, 8'h00, 8'd1, 8'h00, 8'd1};
        vt[9]  = '{1'b0, 8'd2, 8'h00, 3'b001, 8'h05, 8'd1, 8'h05, 8'd1};
        vt[10] = '{1'b1, 8'd2, 8'h05, 3'b010, 8'h05, 8'd1, 8'h05, 8'd1};
        vt[11] = '{1'b1, 8'd1, 8'h07, 3'b010, 8'h05, 8'd2, 8'h05, 8'd2};
        vt[12] = '{1'b1, 8'd1, 8'h03, 3'b010, 8'h05, 8'd3, 8'h05, 8'd2};
        vt[13] = '{1'b0, 8'd1, 8'h00, 3'b001, 8'h03, 8'd3, 8'h07, 8'd2};
        vt[14] = '{1'b1, 8'd1, 8'h09, 3'b010, 8'h03, 8'd4, 8'h07, 8'd3};
        vt[15] = '{1'b0, 8'd1, 8'h00, 3'b001, 8'h09, 8'd4, 8'h09, 8'd3};
        vt[16] = '{1'b0, 8'd8, 8'h00, 3'b100, 8'h09, 8'd4, 8'h09, 8'd3};
        vt[17] = '{1'b1, 8'd8, 8'h55, 3'b100, 8'h09, 8'd4, 8'h09, 8'd3};
        vt[18] = '{1'b0, 8'd0, 8'h00, 3'b001, 8'h00, 8'd4, 8'h00, 8'd3};
        vt[19] = '{1'b1, 8'hFF, 8'h11, 3'b100, 8'h00, 8'd4, 8'h00, 8'd3};
        vt[20] = '{1'b0, 8'd7, 8'h00, 3'b001, 8'h00, 8'd4, 8'h00, 8'd3};
        vt[21] = '{1'b1, 8'd7, 8'h80, 3'b010, 8'h00, 8'd5, 8'h00, 8'd4};
        vt[22] = '{1'b0, 8'd7, 8'h00, 3'b001, 8'h80, 8'd5, 8'h80, 8'd4};

        // Reset with a write of 0xAA to addr 0 held through reset and CLEAR.
        reset = 1'b1; r_w = 1'b1; address_in = 8'd0; data_in = 8'hAA;
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        reset = 1'b0;
        wait_clear("clear");

        for (int i = 0; i < NV; i++) begin
            r_w = vt[i].r_w; address_in = vt[i].addr; data_in = vt[i].data;
            @(negedge clk);
            chk($sformatf("v%0d dout0", i), data_out0, vt[i].dout0);
            chk($sformatf("v%0d dout1", i), data_out1, vt[i].dout1);
            chk($sformatf("v%0d pulses0", i), {5'd0, addr_err0, wr_done0, rd_valid0}, {5'd0, vt[i].pulses});
            chk($sformatf("v%0d pulses1", i), {5'd0, addr_err1, wr_done1, rd_valid1}, {5'd0, vt[i].pulses});
            chk($sformatf("v%0d cnt0", i), wr_count0, vt[i].cnt0);
            chk($sformatf("v%0d cnt1", i), wr_count1, vt[i].cnt1);
            chk($sformatf("v%0d busy", i), {6'd0, busy1, busy0}, 8'h00);
        end

        // 300 distinct writes drive the overwrite counter into saturation.
        m0 = '{8'h00, 8'h09, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80};
        m1 = '{8'h00, 8'h09, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80};
        c0 = 8'd5; c1 = 8'd4;
        for (int i = 0; i < 300; i++) begin
            r_w = 1'b1; address_in = 8'(i % 8); data_in = 8'(i + 1);
            @(negedge clk);
            if (data_in != m0[i % 8]) begin
                m0[i % 8] = data_in;
                if (c0 != 8'hFF) c0 = c0 + 8'd1;
            end
            if (data_in > m1[i % 8]) begin
                m1[i % 8] = data_in;
                if (c1 != 8'hFF) c1 = c1 + 8'd1;
            end
            chk($sformatf("sat w%0d cnt0", i), wr_count0, c0);
        end
        chk("sat cnt0 saturated", wr_count0, 8'hFF);
        chk("sat cnt1", wr_count1, c1);
        chk("sat dout0 held", data_out0, 8'h80);

        // Reset mid-SERVE with a read in flight.
        reset = 1'b1; r_w = 1'b0; address_in = 8'd1;
        @(negedge clk);
        chk_reset_state("reset serve");
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid clear busy", {7'd0, busy0}, 8'h01);
        // Reset mid-CLEAR must restart the full clear.
        reset = 1'b1;
        @(negedge clk);
        chk_reset_state("reset clear");
        reset = 1'b0;
        wait_clear("restart");
        read_all_zero("post");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
